// File: rtl/brick_field_draw.sv
`default_nettype none
// ============================================================================
//  Module      : brick_field_draw
//  Description : Brick wall renderer. On a go pulse it walks every brick slot
//                in row-major order, reads the slot health from brick memory
//                and emits one pixel write per clock for each live brick's
//                rectangle. Outputs feed the brick inputs of draw_mux.
//                Optional feature macro: BRICK_ERASE_EN (dead slots are drawn
//                black instead of being skipped).
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_field_draw #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int BRICK_W  = 16,
    parameter int BRICK_H  = 4,
    parameter int ORIGIN_X = 16,
    parameter int ORIGIN_Y = 8,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [1:0]        mem_health,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic [2:0]        colour,
    output logic              writeEn,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (COLS > 1)    ? $clog2(COLS)    : 1;
    localparam int ROW_W = (ROWS > 1)    ? $clog2(ROWS)    : 1;
    localparam int PX_W  = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
    localparam int PY_W  = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(BRICK_W - 1);
    localparam logic [PY_W-1:0]   PY_LAST   = PY_W'(BRICK_H - 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(ROWS * COLS - 1);

`ifdef BRICK_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_DRAW  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PX_W-1:0]  px;
    logic [PY_W-1:0]  py;

    logic [9:0] base_x;
    logic [9:0] base_y;
    logic       draw_slot;

    // Health to colour; health 0 maps to black so erased slots paint background
    function automatic logic [2:0] health_colour(input logic [1:0] h);
        case (h)
            2'd1:    health_colour = 3'b100;
            2'd2:    health_colour = 3'b110;
            2'd3:    health_colour = 3'b010;
            default: health_colour = 3'b000;
        endcase
    endfunction

    // Top-left pixel of the brick currently addressed by row/col
    assign base_x = 10'(ORIGIN_X) + 10'(col) * 10'(BRICK_W);
    assign base_y = 10'(ORIGIN_Y) + 10'(row) * 10'(BRICK_H);

    // A slot is rendered if it is live, or always when dead bricks are erased
    assign draw_slot = ERASE_EN || (mem_health != 2'd0);

    // Sweep state machine; all outputs are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            col      <= '0;
            row      <= '0;
            px       <= '0;
            py       <= '0;
            mem_addr <= '0;
            x_out    <= '0;
            y_out    <= '0;
            colour   <= '0;
            writeEn  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        col      <= '0;
                        row      <= '0;
                        px       <= '0;
                        py       <= '0;
                        mem_addr <= '0;
                    end
                end
                S_FETCH: begin
                    // mem_addr is already presented; memory answers next cycle
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    colour <= health_colour(mem_health);
                    if (draw_slot) begin
                        state   <= S_DRAW;
                        writeEn <= 1'b1;
                        px      <= '0;
                        py      <= '0;
                        x_out   <= base_x;
                        y_out   <= base_y;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (px == PX_LAST) begin
                        px    <= '0;
                        x_out <= base_x;
                        if (py == PY_LAST) begin
                            py      <= '0;
                            writeEn <= 1'b0;
                            state   <= S_NEXT;
                        end else begin
                            py    <= py + 1'b1;
                            y_out <= y_out + 10'd1;
                        end
                    end else begin
                        px    <= px + 1'b1;
                        x_out <= x_out + 10'd1;
                    end
                end
                S_NEXT: begin
                    if (mem_addr == LAST_SLOT) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    writeEn <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_brick_field_draw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_field_draw
//  Description : Self-checking bench for brick_field_draw. Expected pixels
//                are queued from a memory model before each sweep and popped
//                as the design writes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_field_draw;

    localparam int NSLOT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [1:0] mem_health = 2'd0;
    logic [9:0] mem_addr;
    logic [9:0] x_out;
    logic [9:0] y_out;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       done;

    brick_field_draw dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .mem_health (mem_health),
        .mem_addr   (mem_addr),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .writeEn    (writeEn),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [0:1023];
    always @(posedge clk) mem_health <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [22:0] exp_q [$];
    logic [22:0] mon_exp;
    bit          wen_exp [0:4095];
    int          fetch_rel [0:NSLOT-1];
    int          n_assert = 0;
    int          n_fail = 0;
    int          write_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_colour(input logic [1:0] h);
        case (h)
            2'd1:    return 3'b100;
            2'd2:    return 3'b110;
            2'd3:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit slot_drawn(input int s);
`ifdef BRICK_ERASE_EN
        return 1'b1;
`else
        return mem[s] != 2'd0;
`endif
    endfunction

    // Scoreboard consumer: every write must match the next queued pixel
    always @(negedge clk) begin
        if (reset === 1'b0 && writeEn === 1'b1) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {x_out, y_out, colour}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pixel", {9'd0, x_out, y_out, colour}, {9'd0, mon_exp});
            end
        end
    end

    // Build expected pixels, writeEn profile and done cycle from the memory image
    task automatic load_expect(output int done_rel, output int n_writes);
        int r;
        r = 1;
        n_writes = 0;
        for (int i = 0; i < 4096; i++) wen_exp[i] = 1'b0;
        exp_q.delete();
        for (int s = 0; s < NSLOT; s++) begin
            fetch_rel[s] = r;
            if (slot_drawn(s)) begin
                r += 2;
                for (int py = 0; py < 4; py++) begin
                    for (int px = 0; px < 16; px++) begin
                        exp_q.push_back({10'(16 + (s % 8) * 16 + px),
                                         10'(8 + (s / 8) * 4 + py),
                                         exp_colour(mem[s])});
                        wen_exp[r] = 1'b1;
                        r++;
                        n_writes++;
                    end
                end
                r += 1;
            end else begin
                r += 3;
            end
        end
        done_rel = r;
    endtask

    task automatic run_sweep(input string tag, input int chk_slot,
                             input int glitch_rel, input int abort_rel);
        int done_rel, n_writes, t0, busy_err, done_err, wen_err, pre_writes;
        busy_err = 0;
        done_err = 0;
        wen_err  = 0;
        load_expect(done_rel, n_writes);
        write_cnt = 0;
        @(negedge clk); #1;
        go = 1'b1;
        t0 = cyc;
        for (int rel = 1; rel <= done_rel + 2; rel++) begin
            @(negedge clk); #1;
            if (rel == 1) go = 1'b0;
            if (rel == glitch_rel) go = 1'b1;
            if (rel == glitch_rel + 1) go = 1'b0;
            if (cyc - t0 != rel) check({tag, "_cycle_sync"}, cyc - t0, rel);
            if (chk_slot >= 0 && rel == fetch_rel[chk_slot])
                check({tag, "_fetch_addr"}, {22'd0, mem_addr}, chk_slot);
            if (rel == abort_rel) begin
                pre_writes = 0;
                for (int i = 1; i <= abort_rel; i++) if (wen_exp[i]) pre_writes++;
                check({tag, "_pre_abort_wen"}, writeEn, 1);
                check({tag, "_pre_abort_writes"}, write_cnt, pre_writes);
                reset = 1'b1;
                #1;
                check({tag, "_abort_wen"}, writeEn, 0);
                check({tag, "_abort_busy"}, busy, 0);
                check({tag, "_abort_addr"}, {22'd0, mem_addr}, 0);
                exp_q.delete();
                @(negedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (busy !== (rel <= done_rel)) busy_err++;
            if (done !== (rel == done_rel)) done_err++;
            if (writeEn !== wen_exp[rel]) wen_err++;
        end
        check({tag, "_busy_profile_errs"}, busy_err, 0);
        check({tag, "_done_pulse_errs"}, done_err, 0);
        check({tag, "_wen_profile_errs"}, wen_err, 0);
        check({tag, "_write_count"}, write_cnt, n_writes);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 2'd0;
        reset = 1'b1;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_colour", colour, 0);
        check("rst_wen", writeEn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All slots dead
        run_sweep("all_dead", -1, 0, 0);

        // Only slot 0 live, health 3
        mem[0] = 2'd3;
        run_sweep("slot0_h3", 0, 0, 0);
        mem[0] = 2'd0;

        // Only slot 31 live, health 1
        mem[31] = 2'd1;
        run_sweep("slot31_h1", 31, 0, 0);
        mem[31] = 2'd0;

        // All slots health 2, with a go pulse mid-sweep that must be ignored
        for (int s = 0; s < NSLOT; s++) mem[s] = 2'd2;
        run_sweep("all_h2", 7, 500, 0);
        for (int s = 0; s < NSLOT; s++) mem[s] = 2'd0;

        // Reset in the middle of drawing slot 5
        mem[5] = 2'd2;
        run_sweep("abort", 5, 0, 30);
        mem[5] = 2'd0;

        // Fresh sweep after the abort must restart at slot 0
        run_sweep("restart", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
